// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: a Moore FSM that sequences a shared datapath
// through fetch/decode/execute/memory/writeback, stalling on mem_ready.
//
// Ports:
//   clk, reset         clock, async active-high reset (forces FETCH)
//   op                 instr[31:26], used only in DECODE and MEMADR
//   zero               ALU zero flag (feeds pcen for beq)
//   mem_ready          memory finishes its access this cycle
//   mem_req            memory access requested
//   iord .. branch     datapath selects
//   irwrite, regwrite, memwrite, pcen   write enables
//   alusrcb, pcsrc, aluop              2-bit selects
//   illegal_op         undefined opcode seen in DECODE
//   state              current state (debug)
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic       branch,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       pcen,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       pcwrite;
  logic       is_r, is_lw, is_sw, is_beq, is_addi, is_j;

  assign is_r    = (op == OP_R);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_addi = (op == OP_ADDI);
  assign is_j    = (op == OP_J);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_d = S_MEMADR;
          is_r:         state_d = S_RTYPEEX;
          is_beq:       state_d = S_BEQEX;
          is_addi:      state_d = S_ADDIEX;
          is_j:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      // op is re-sampled here; anything but lw/sw abandons the access
      S_MEMADR: begin
        unique case (1'b1)
          is_lw:   state_d = S_MEMRD;
          is_sw:   state_d = S_MEMWR;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    branch     = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    pcwrite    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        // IR and PC only load once the fetch completes
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        illegal_op = ~(is_r | is_lw | is_sw | is_beq | is_addi | is_j);
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the driver expands each instruction
// into its expected per-cycle state/control sequence; a monitor compares.
module tb_mc_controller;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, iord, alusrca, regdst, memtoreg, branch;
  logic       irwrite, regwrite, memwrite, pcen, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  typedef struct {
    logic [20:0] w;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  logic [20:0] act_w;
  assign act_w = {state, mem_req, iord, alusrca, regdst, memtoreg, branch,
                  irwrite, regwrite, memwrite, pcen,
                  alusrcb, pcsrc, aluop, illegal_op};

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord),
    .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg),
    .branch(branch), .irwrite(irwrite), .regwrite(regwrite),
    .memwrite(memwrite), .pcen(pcen), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 if (clk_run) clk = ~clk;

  function automatic logic legal(input logic [5:0] o);
    return o == OP_R || o == OP_LW || o == OP_SW ||
           o == OP_BEQ || o == OP_ADDI || o == OP_J;
  endfunction

  // Expected outputs for one cycle, straight from the control-word table
  function automatic logic [20:0] exp_word(input logic [3:0] s,
      input logic mr, input logic z, input logic [5:0] o);
    logic rq, io, sa, rd, mt, br, iw, rw, mw, pw, il;
    logic [1:0] sb, ps, ao;
    {rq, io, sa, rd, mt, br, iw, rw, mw, pw, il} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    if (s == 4'd0) begin rq = 1; sb = 2'b01; iw = mr; pw = mr; end
    if (s == 4'd1) begin sb = 2'b11; il = !legal(o); end
    if (s == 4'd2 || s == 4'd9) begin sa = 1; sb = 2'b10; end
    if (s == 4'd3) begin rq = 1; io = 1; end
    if (s == 4'd4) begin mt = 1; rw = 1; end
    if (s == 4'd5) begin rq = 1; io = 1; mw = 1; end
    if (s == 4'd6) begin sa = 1; ao = 2'b10; end
    if (s == 4'd7) begin rd = 1; rw = 1; end
    if (s == 4'd8) begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
    if (s == 4'd10) rw = 1;
    if (s == 4'd11) begin ps = 2'b10; pw = 1; end
    return {s, rq, io, sa, rd, mt, br, iw, rw, mw, pw | (br & z),
            sb, ps, ao, il};
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [20:0] act,
                       input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue what the outputs must be
  task automatic cyc(input logic [3:0] s, input logic [5:0] o,
                     input logic mr, input logic z);
    exp_t e;
    op = o; mem_ready = mr; zero = z;
    e.w = exp_word(s, mr, z, o);
    e.id = cyc_n;
    exp_q.push_back(e);
    cyc_n++;
    @(posedge clk); #1;
  endtask

  // Expand one instruction into its state path; op is scrambled wherever
  // the controller must ignore it
  task automatic run_instr(input logic [5:0] o, input logic z,
                           input int sf, input int sm);
    for (int i = 0; i < sf; i++) cyc(4'd0, rop(), 1'b0, rb());
    cyc(4'd0, rop(), 1'b1, rb());
    cyc(4'd1, o, rb(), rb());
    case (o)
      OP_LW: begin
        cyc(4'd2, o, rb(), rb());
        for (int i = 0; i < sm; i++) cyc(4'd3, rop(), 1'b0, rb());
        cyc(4'd3, rop(), 1'b1, rb());
        cyc(4'd4, rop(), rb(), rb());
      end
      OP_SW: begin
        cyc(4'd2, o, rb(), rb());
        for (int i = 0; i < sm; i++) cyc(4'd5, rop(), 1'b0, rb());
        cyc(4'd5, rop(), 1'b1, rb());
      end
      OP_R: begin
        cyc(4'd6, rop(), rb(), rb());
        cyc(4'd7, rop(), rb(), rb());
      end
      OP_BEQ: cyc(4'd8, rop(), rb(), z);
      OP_ADDI: begin
        cyc(4'd9, rop(), rb(), rb());
        cyc(4'd10, rop(), rb(), rb());
      end
      OP_J: cyc(4'd11, rop(), rb(), rb());
      default: ;
    endcase
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cyc%0d_st%0d", e.id, e.w[20:17]), act_w, e.w);
      end
    end
  end

  initial begin
    logic [5:0] ops[6];
    logic [5:0] o;
    int w;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    reset = 1'b0; op = 6'h3f; zero = 1'b1; mem_ready = 1'b0;

    // async reset with the clock stopped
    #3 reset = 1'b1;
    #1 check("rst_idle_mr0", act_w, exp_word(4'd0, 1'b0, zero, op));
    mem_ready = 1'b1;
    #1 check("rst_idle_mr1", act_w, exp_word(4'd0, 1'b1, zero, op));
    clk_run = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_instr(OP_LW, 1'b0, 0, 0);
    run_instr(OP_SW, 1'b0, 0, 2);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_ADDI, 1'b0, 0, 0);
    run_instr(OP_J, 1'b0, 0, 0);
    run_instr(6'b111111, 1'b0, 0, 0);
    run_instr(OP_LW, 1'b0, 2, 1);

    // reset pulsed while in RTYPEEX
    cyc(4'd0, rop(), 1'b1, rb());
    cyc(4'd1, OP_R, rb(), rb());
    begin
      exp_t e6;
      op = rop(); mem_ready = rb(); zero = rb();
      e6.w = exp_word(4'd6, mem_ready, zero, op);
      e6.id = cyc_n++;
      exp_q.push_back(e6);
    end
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("rst_mid_rtypeex", act_w, exp_word(4'd0, mem_ready, zero, op));
    @(posedge clk);
    #1 reset = 1'b0;

    repeat (60) begin
      int k;
      k = $urandom_range(0, 6);
      if (k < 6) o = ops[k];
      else begin
        o = rop();
        while (legal(o)) o = rop();
      end
      run_instr(o, rb(), $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
                $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0);
    end

    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the MIPS core: a Moore state machine that sequences the shared datapath (one memory, one ALU) through fetch, decode, execute, memory and writeback steps for R-type, lw, sw, beq, addi and j. It replaces single-cycle decoding with per-state control words. It also stalls on a memory ready handshake and flags undefined opcodes.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  6  opcode field of instruction register (instr[31:26])
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access requested (FETCH, MEMRD, MEMWR)
- iord, alusrca, regdst, memtoreg, branch  out  1 each  datapath selects
- irwrite, regwrite, memwrite  out  1 each  write enables
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- alusrcb  out  2  ALU B select (00 reg, 01 const 4, 10 signimm, 11 signimm<<2)
- pcsrc  out  2  PC source (00 ALU result, 01 ALU out reg, 10 jump target)
- aluop  out  2  to ALU decoder (00 add, 01 sub, 10 use funct)
- illegal_op  out  1  undefined opcode seen in DECODE
- state  out  4  current state, debug

## Operation
- State register 4 bits, encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11; codes 12-15 go to FETCH next cycle with all outputs 0.
- Opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 001000 addi, 000010 j.
- Transitions: FETCH->DECODE (on mem_ready); DECODE->MEMADR (lw/sw), RTYPEEX, BEQEX, ADDIEX, JEX, else FETCH with illegal_op=1; MEMADR->MEMRD (lw) / MEMWR (sw); MEMRD->MEMWB (on mem_ready); MEMWR->FETCH (on mem_ready); RTYPEEX->RTYPEWB; ADDIEX->ADDIWB; MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX->FETCH.
- Control words (unlisted signals 0):
  - FETCH: mem_req=1, alusrcb=01, irwrite=mem_ready, pcwrite=mem_ready
  - DECODE: alusrcb=11
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10
  - MEMRD: mem_req=1, iord=1
  - MEMWR: mem_req=1, iord=1, memwrite=1 (held until mem_ready)
  - MEMWB: memtoreg=1, regwrite=1
  - RTYPEEX: alusrca=1, aluop=10
  - RTYPEWB: regdst=1, regwrite=1
  - ADDIWB: regwrite=1
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1
  - JEX: pcsrc=10, pcwrite=1
- op is sampled only in DECODE and MEMADR. Changes in other states have no effect.
- illegal_op is combinational and high only in DECODE with an undefined op.

## Timing
- Reset asserted: state=0 immediately, without waiting for a clock edge. Outputs are the FETCH word: mem_req=1, alusrcb=01, and irwrite/pcwrite/pcen follow mem_ready. All other outputs are 0.
- Reset released mid-instruction: fetch restarts from FETCH. Partial instruction is discarded.
- Outputs are decoded from state (Moore). Exceptions: pcen depends on zero, and FETCH irwrite/pcwrite depend on mem_ready. These three are combinational from inputs.
- Cycle counts with mem_ready held at 1: beq 3, j 3, R-type 4, addi 4, sw 4, lw 5, illegal 2.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. During the stall, state holds and no register or PC write enable is asserted. memwrite stays high throughout MEMWR.
- beq not taken (zero=0): pcen=0 in BEQEX, next state FETCH.

## Test plan
- Reset asserted with clk idle -> state=0 at once; with mem_ready=0: mem_req=1, alusrcb=01, pcen=0, irwrite=0.
- lw (op=100011), mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in cycle 5.
- sw (op=101011), mem_ready low for 2 cycles in MEMWR -> MEMWR held 3 cycles with memwrite=1; then FETCH.
- beq with zero=1 -> BEQEX: pcen=1, pcsrc=01, aluop=01. With zero=0 -> pcen=0. Both go to FETCH next cycle.
- R-type, addi, j back-to-back with mem_ready=1 -> 4, 4 and 3 cycles. JEX: pcsrc=10, pcen=1. RTYPEWB: regdst=1.
- op=111111 -> illegal_op=1 for one cycle in DECODE, then FETCH, no write enable. Separately, reset pulsed during RTYPEEX -> state=0 with no regwrite.
